alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequencer that drives the 32-bit ALU in the ALU checker. It assembles the A and B operands from an 8-bit byte stream and drives `alucontrol` with either one chosen operation or a sweep of all operations. After each operation it captures the ALU result and flags and hands them to the display/readout logic through a valid/ready handshake. It sits between the board-level byte input and the `alu` instance, and replaces the per-byte operand registers clocked by the demux.

## Interface
- `OP_COUNT`, default 10: number of ALU operations swept in sweep mode (codes `0..OP_COUNT-1`).
- `SETTLE`, default 1: number of cycles `alucontrol`/operands are held stable before the result is captured. Must be at least 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `sweep`  in  1  latched with `start`; 1 = sweep ops `0..OP_COUNT-1`, 0 = single op.
- `op_in`  in  4  operation code for single mode; latched with `start`.
- `byte_in`  in  8  operand byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  sequencer accepts a byte.
- `a`  out  32  operand A to the ALU.
- `b`  out  32  operand B to the ALU.
- `alucontrol`  out  4  operation code to the ALU.
- `alu_result`  in  32  combinational ALU result.
- `alu_flags`  in  4  combinational ALU flags.
- `result`  out  32  captured result.
- `flags`  out  4  captured flags.
- `res_op`  out  4  op code belonging to `result`.
- `res_valid`  out  1  `result`/`flags`/`res_op` are valid.
- `res_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a test completes.

## Operation
- States:
  - IDLE → LOAD on `start`. This cycle latches `sweep` and loads the op register with `op_in` (single mode) or 0 (sweep mode). `start` is ignored outside IDLE.
  - LOAD: `byte_ready`=1. A byte is accepted on each edge where `byte_valid`&&`byte_ready`. A 3-bit byte counter selects the destination:
    - bytes 0–3 → `a[7:0]`, `a[15:8]`, `a[23:16]`, `a[31:24]`;
    - bytes 4–7 → `b[7:0]` … `b[31:24]`.
    - Acceptance of byte 7 → EXEC, counter cleared.
    - Idle cycles (`byte_valid`=0) hold state and counter.
  - EXEC: holds for `SETTLE` cycles; `alucontrol` = op register. On the last EXEC edge: `result`←`alu_result`, `flags`←`alu_flags`, `res_op`←op register, then → OUT.
  - OUT: `res_valid`=1 until the `res_ready` handshake edge. On that edge:
    - sweep mode and op < `OP_COUNT-1`: op increments, → EXEC;
    - otherwise: → IDLE with `done`=1 for the following cycle.
- Operands are loaded once per test; every swept op uses the same `a`/`b`.
- `a`, `b`, `alucontrol`, `result`, `flags`, `res_op` hold their values after `done` until the next test overwrites them.
- A LOAD that starts while old operands are held updates `a`/`b` byte by byte; partial values are visible on the ports.
- Op register is 4 bits. In single mode `op_in` is passed through even if it is ≥ `OP_COUNT`.

## Timing
- Reset (`rst_n`=0, asynchronous, any state including mid-LOAD, EXEC or OUT): state IDLE, byte counter 0, and all of the following are 0: `a`, `b`, `alucontrol`, `result`, `flags`, `res_op`, `res_valid`, `byte_ready`, `busy`, `done`. A test in progress is discarded.
- `start` edge → `byte_ready`=1 and `busy`=1 from the next cycle.
- Maximum load rate is one byte per cycle: 8 cycles minimum.
- Byte 7 accepted on edge E → `res_valid` rises `SETTLE` edges after E (E+1 for the default).
- `res_ready` held high: each further sweep op costs `SETTLE`+1 cycles. A single-mode test with back-to-back bytes takes 8+`SETTLE`+1 cycles from the first `byte_ready` to `done`.
- `res_ready` may be high before `res_valid`; it has no effect outside OUT.
- `done` coincides with the first IDLE cycle. A `start` in that same cycle is accepted.
- `byte_valid` outside LOAD is ignored; no bytes are consumed.

## Test plan
- **Single ADD.** Reset, `start` with `sweep`=0, `op_in`=0. Bytes 01 00 00 00 FF FF FF 7F → `a`=0x00000001, `b`=0x7FFFFFFF, `res_valid` at E+1, `result`=0x80000000 (V flag per the ALU), `res_op`=0, `done` pulses once.
- **Full sweep.** `sweep`=1, `a`=0xF0F0F0F0, `b`=0x00000004, `res_ready` tied high → exactly 10 handshakes with `res_op` 0..9 in order, 2 cycles apart. Each `result` matches the ALU model. `done` after the 10th handshake.
- **Backpressure.** `res_ready`=0 for 5 cycles in OUT → `res_valid` and `result` stable and `alucontrol` unchanged. Op advances only after `res_ready` rises.
- **Gapped bytes.** `byte_valid` toggling every other cycle → all 8 bytes land in the correct lanes. `busy`=1 throughout; `start` pulses during LOAD are ignored.
- **Reset mid-operation.** `rst_n` low after byte 5, and again during a sweep at op 3 → all outputs 0 immediately (asynchronously). After release, a new test runs normally from byte 0.
- **Back-to-back tests.** `start` asserted in the `done` cycle → new test accepted. The previous `result` is held until the new capture.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : byte-stream operand loader and single/sweep op sequencer
//                    for the ALU checker, with valid/ready result hand-off.
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_op_sequencer #(
    parameter int OP_COUNT = 10,
    parameter int SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sweep,
    input  logic [3:0]  op_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  alucontrol,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [3:0]  res_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        done
);

    localparam int             c_SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE - 1);
    localparam logic [3:0]     c_LAST_OP     = 4'(OP_COUNT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_EXEC = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [2:0]         cnt_q,    cnt_d;
    logic [c_SET_W-1:0] settle_q, settle_d;
    logic               sweep_q,  sweep_d;
    logic [3:0]         op_q,     op_d;
    logic [31:0]        a_q,      a_d;
    logic [31:0]        b_q,      b_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         flags_q,  flags_d;
    logic [3:0]         res_op_q, res_op_d;
    logic               done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        sweep_d  = sweep_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        res_op_d = res_op_q;
        done_d   = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_LOAD;
                    sweep_d = sweep;
                    op_d    = sweep ? 4'd0 : op_in;
                    cnt_d   = 3'd0;
                end
            end
            c_LOAD: begin
                if (byte_valid) begin
                    // cnt[2] picks the operand, cnt[1:0] the byte lane within it
                    if (!cnt_q[2]) begin
                        a_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
                    end else begin
                        b_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d  = c_EXEC;
                        settle_d = '0;
                    end
                end
            end
            c_EXEC: begin
                if (settle_q == c_SETTLE_LAST) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    res_op_d = op_q;
                    state_d  = c_OUT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            c_OUT: begin
                if (res_ready) begin
                    if (sweep_q && (op_q < c_LAST_OP)) begin
                        op_d     = op_q + 4'd1;
                        settle_d = '0;
                        state_d  = c_EXEC;
                    end else begin
                        state_d = c_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            cnt_q    <= 3'd0;
            settle_q <= '0;
            sweep_q  <= 1'b0;
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
            res_op_q <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            sweep_q  <= sweep_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            res_op_q <= res_op_d;
            done_q   <= done_d;
        end
    end

    // The op register drives the ALU directly so the last code stays visible after done.
    assign alucontrol = op_q;
    assign a          = a_q;
    assign b          = b_q;
    assign result     = result_q;
    assign flags      = flags_q;
    assign res_op     = res_op_q;
    assign done       = done_q;
    assign byte_ready = (state_q == c_LOAD);
    assign res_valid  = (state_q == c_OUT);
    assign busy       = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : directed self-checking bench with a scoreboard model.
// Revision            : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sweep = 1'b0;
    logic [3:0]  op_in = 4'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] a, b;
    logic [3:0]  alucontrol;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  res_op;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          mcnt = 0;
    bit          chk_en = 1'b0;
    logic [31:0] model_a = 32'd0;
    logic [31:0] model_b = 32'd0;
    logic [3:0]  sbq[$];
    int          hs_times[$];

    alu_op_sequencer #(.OP_COUNT(10), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep(sweep), .op_in(op_in),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .a(a), .b(b), .alucontrol(alucontrol),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .result(result), .flags(flags), .res_op(res_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference ALU: flags are {N, Z, C, V}; C is carry for ADD and no-borrow for SUB.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = 32'd0; s = 33'd0;
        case (op)
            4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; c = s[32];
                        v = (x[31] == y[31]) && (r[31] != x[31]); end
            4'd1: begin s = {1'b0, x} - {1'b0, y}; r = s[31:0]; c = ~s[32];
                        v = (x[31] != y[31]) && (r[31] != x[31]); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~(x | y);
            4'd6: r = x << y[4:0];
            4'd7: r = x >> y[4:0];
            4'd8: r = $signed(x) >>> y[4:0];
            4'd9: r = {31'd0, ($signed(x) < $signed(y))};
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alucontrol, a, b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the operand/scoreboard model, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (!rst_n) begin
                model_a = 32'd0; model_b = 32'd0; mcnt = 0;
                sbq.delete();
                chk("rst_ab", {a, b}, 64'd0);
                chk("rst_ctl", {alucontrol, result, flags, res_op, res_valid, byte_ready, busy, done}, 64'd0);
            end else begin
                chk("oper_a", a, model_a);
                chk("oper_b", b, model_b);
                if (res_valid) chk("alucontrol_vs_res_op", alucontrol, res_op);
                if (res_valid && res_ready) begin
                    hs_times.push_back(cyc);
                    if (sbq.size() == 0) begin
                        chk("unexpected_handshake", 1'b1, 1'b0);
                    end else begin
                        logic [3:0]  eop;
                        logic [35:0] exp;
                        eop = sbq.pop_front();
                        exp = alu_fn(eop, model_a, model_b);
                        chk("sb_res_op", res_op, eop);
                        chk("sb_result", result, exp[31:0]);
                        chk("sb_flags", flags, exp[35:32]);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_all_results_seen", sbq.size(), 0);
                end
                if (byte_valid && byte_ready) begin
                    if (mcnt < 4) model_a[mcnt*8 +: 8] = byte_in;
                    else          model_b[(mcnt-4)*8 +: 8] = byte_in;
                    mcnt = (mcnt + 1) % 8;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("async_rst_ab", {a, b}, 64'd0);
        chk("async_rst_ctl", {alucontrol, result, flags, res_op, res_valid, byte_ready, busy, done}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start(input logic sw, input logic [3:0] op);
        start = 1'b1; sweep = sw; op_in = op;
        tick();
        start = 1'b0; sweep = 1'b0; op_in = 4'd0;
        if (sw) for (int i = 0; i < 10; i++) sbq.push_back(4'(i));
        else    sbq.push_back(op);
        chk("start_busy_ready", {busy, byte_ready}, 2'b11);
    endtask

    task automatic send_bytes(input logic [31:0] va, input logic [31:0] vb,
                              input bit gap, input bit noise, input int n);
        logic [63:0] all;
        all = {vb, va};
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_in    = all[i*8 +: 8];
            tick();
            if (i < 7) chk("load_busy", {busy, byte_ready}, 2'b11);
            if (gap && i < 7) begin
                byte_valid = 1'b0;
                byte_in    = 8'h5A;
                if (noise) begin start = 1'b1; sweep = 1'b1; op_in = 4'd7; end
                tick();
                start = 1'b0; sweep = 1'b0; op_in = 4'd0;
                chk("gap_busy", {busy, byte_ready}, 2'b11);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done; i++) tick();
        chk("done_seen", done, 1'b1);
    endtask

    int dc0;

    initial begin
        tick();
        do_reset();

        // Single ADD: 1 + 0x7FFFFFFF overflows into the sign bit
        res_ready = 1'b1;
        dc0 = done_cnt;
        do_start(1'b0, 4'd0);
        send_bytes(32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 8);
        chk("add_no_valid_at_e", res_valid, 1'b0);
        tick();
        chk("add_valid_e1", res_valid, 1'b1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_flags", flags, 4'b1001);
        chk("add_res_op", res_op, 4'd0);
        chk("add_ab", {a, b}, {32'h0000_0001, 32'h7FFF_FFFF});
        tick();
        chk("add_done_idle", {done, busy}, 2'b10);
        tick();
        chk("add_done_one_pulse", {done, 28'(done_cnt - dc0)}, {1'b0, 28'd1});

        // Full sweep with res_ready tied high; stray byte_valid outside LOAD
        hs_times.delete();
        dc0 = done_cnt;
        do_start(1'b1, 4'd0);
        send_bytes(32'hF0F0_F0F0, 32'h0000_0004, 1'b0, 1'b0, 8);
        byte_valid = 1'b1; byte_in = 8'hEE;
        wait_done(60);
        byte_valid = 1'b0;
        chk("sweep_handshakes", hs_times.size(), 10);
        for (int i = 1; i < hs_times.size(); i++)
            chk("sweep_spacing", hs_times[i] - hs_times[i-1], 2);
        tick();
        chk("sweep_done_count", done_cnt - dc0, 1);

        // Backpressure on op 0 of a sweep
        res_ready = 1'b0;
        do_start(1'b1, 4'd0);
        send_bytes(32'hF0F0_F0F0, 32'h0000_0004, 1'b0, 1'b0, 8);
        for (int i = 0; i < 10 && !res_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ctl", {res_valid, alucontrol, res_op}, {1'b1, 4'd0, 4'd0});
            chk("bp_hold_res", {flags, result}, {4'b1000, 32'hF0F0_F0F4});
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_advance", {res_valid, alucontrol}, {1'b0, 4'd1});
        wait_done(60);
        tick();

        // Gapped bytes with ignored start pulses; XOR
        do_start(1'b0, 4'd4);
        send_bytes(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1, 8);
        tick();
        chk("xor_result", {res_valid, res_op, result}, {1'b1, 4'd4, 32'h1D3B_5977});
        wait_done(10);
        tick();

        // Reset after byte 5, then a clean SUB test
        do_start(1'b0, 4'd1);
        send_bytes(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 6);
        do_reset();
        do_start(1'b0, 4'd1);
        send_bytes(32'd10, 32'd3, 1'b0, 1'b0, 8);
        tick();
        chk("sub_result", {flags, result}, {4'b0010, 32'd7});
        wait_done(10);
        tick();

        // Reset during sweep at op 3
        do_start(1'b1, 4'd0);
        send_bytes(32'hF0F0_F0F0, 32'h0000_0004, 1'b0, 1'b0, 8);
        for (int i = 0; i < 30 && !(res_valid && res_op == 4'd3); i++) tick();
        chk("sweep_reached_op3", {res_valid, res_op}, {1'b1, 4'd3});
        do_reset();

        // Back-to-back: start in the done cycle; old result held until new capture
        do_start(1'b0, 4'd2);
        send_bytes(32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 1'b0, 8);
        wait_done(10);
        do_start(1'b0, 4'd15);
        send_bytes(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 8);
        chk("b2b_result_held", {res_op, result}, {4'd2, 32'h0F00_0F00});
        tick();
        chk("b2b_op15", {alucontrol, res_op, result}, {4'd15, 4'd15, 32'd0});
        wait_done(10);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
